micro_datapath: RTL and testbench



---
 rtl/micro_datapath.sv | 163 ++++++++++++++++
 tb/tb_micro_datapath.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/micro_datapath.sv
// Microprogrammed datapath: register file, ALU, and a sequencer that runs a loadable program.
// Optional watchdog abort is built when MICRO_DATAPATH_WDOG_EN is defined.
module micro_datapath #(
    parameter int P_N       = 16,
    parameter int P_REGS    = 16,
    parameter int P_DEPTH   = 32,
    parameter int P_OUT_REG = 2,
    parameter int P_WDOG    = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           prog_we,
    input  logic [4:0]     prog_addr,
    input  logic [19:0]    prog_data,
    input  logic           start,
    input  logic [P_N-1:0] ext_in,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [P_N-1:0] result
);
    localparam int RW = (P_REGS > 1) ? $clog2(P_REGS) : 1;
    localparam int AW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SHR  = 3'b100;
    localparam logic [2:0] OP_LDI  = 3'b101;
    localparam logic [2:0] OP_BR   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    logic [0:0]     state;
    logic [AW-1:0]  pc;
    logic [19:0]    mem [P_DEPTH];
    logic [P_N-1:0] rf  [P_REGS];

    logic [19:0]    ir;
    logic [2:0]     op;
    logic [RW-1:0]  ra, rb, rd;
    logic [1:0]     cond;
    logic [AW-1:0]  tgt;
    logic [P_N-1:0] opa, opb, alu_res;
    logic           wr_en, br_taken, running, halt, wdog_trip;

    assign ir      = mem[pc];
    assign op      = ir[19:17];
    assign ra      = ir[13 +: RW];
    assign rb      = ir[9 +: RW];
    assign rd      = ir[5 +: RW];
    assign cond    = ir[6:5];
    assign tgt     = ir[0 +: AW];
    assign opa     = rf[ra];
    assign opb     = rf[rb];
    assign running = (state == S_RUN);
    assign halt    = running && (op == OP_HALT);
    assign busy    = running;
    assign result  = rf[P_OUT_REG % P_REGS];

    always_comb begin
        alu_res = '0;
        wr_en   = 1'b0;
        case (op)
            OP_ADD: begin alu_res = opa + opb;  wr_en = 1'b1; end
            OP_SUB: begin alu_res = opa - opb;  wr_en = 1'b1; end
            OP_AND: begin alu_res = opa & opb;  wr_en = 1'b1; end
            OP_OR:  begin alu_res = opa | opb;  wr_en = 1'b1; end
            OP_SHR: begin alu_res = opa >> 1;   wr_en = 1'b1; end
            OP_LDI: begin alu_res = ext_in;     wr_en = 1'b1; end
            default: ;
        endcase
    end

    // Branch condition lives in the low two bits of the dst field.
    always_comb begin
        br_taken = 1'b0;
        case (cond)
            2'b00: br_taken = 1'b1;
            2'b01: br_taken = (opa > opb);
            2'b10: br_taken = ~opa[0];
            2'b11: br_taken = (opa == opb);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && prog_we)
            mem[prog_addr[AW-1:0]] <= prog_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < P_REGS; i++)
                rf[i] <= '0;
        end else if (running && wr_en) begin
            rf[rd] <= alu_res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        pc    <= '0;
                    end
                end
                default: begin
                    if (halt) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else if (wdog_trip) begin
                        state <= S_IDLE;
                    end else if (op == OP_BR && br_taken) begin
                        pc <= tgt;
                    end else begin
                        pc <= pc + AW'(1);
                    end
                end
            endcase
        end
    end

`ifdef MICRO_DATAPATH_WDOG_EN
    logic [15:0] wdog_cnt;
    logic        err_q;

    // Trips on the P_WDOG-th non-HALT run cycle; that cycle's register write still lands.
    assign wdog_trip = running && !halt && (wdog_cnt == 16'(P_WDOG - 1));
    assign err       = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state == S_IDLE && start)
                wdog_cnt <= '0;
            else if (running && !halt) begin
                if (wdog_trip)
                    err_q <= 1'b1;
                else
                    wdog_cnt <= wdog_cnt + 16'd1;
            end
        end
    end
`else
    assign wdog_trip = 1'b0;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_micro_datapath.sv
// Directed self-checking bench for micro_datapath (default 16-bit, 16 regs, 32-deep, watchdog limit 20).
module tb_micro_datapath;
    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [19:0] prog_data;
    logic        start;
    logic [15:0] ext_in;
    logic        busy, done, err;
    logic [15:0] result;

    logic [19:0] prog_tab [0:31];
    logic [15:0] ext_tab  [0:63];
    int n_checks = 0;
    int n_pass   = 0;

    micro_datapath #(.P_N(16), .P_REGS(16), .P_DEPTH(32), .P_OUT_REG(2), .P_WDOG(20)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .start(start), .ext_in(ext_in), .busy(busy), .done(done), .err(err), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] enc(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] d, input logic [4:0] t);
        return {op, a, b, d, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ext();
        for (int i = 0; i < 64; i++) ext_tab[i] = '0;
    endtask

    task automatic load_prog(input int n);
        for (int i = 0; i < n; i++) begin
            prog_we   = 1'b1;
            prog_addr = 5'(i);
            prog_data = prog_tab[i];
            tick();
        end
        prog_we = 1'b0;
    endtask

    // Pulses start, then feeds ext_tab[k] during the cycle instruction k executes.
    task automatic run_prog(input int limit, input int disturb_cyc, output int bc, output int dc, output int ec);
        int cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        bc = 0; dc = 0; ec = 0; cyc = 0;
        while (busy === 1'b1 && cyc < limit) begin
            ext_in = ext_tab[cyc];
            if (cyc == disturb_cyc) begin
                start     = 1'b1;
                prog_we   = 1'b1;
                prog_addr = 5'd0;
                prog_data = enc(3'b111, 4'd0, 4'd0, 4'd0, 5'd0);
            end
            tick();
            start   = 1'b0;
            prog_we = 1'b0;
            bc++;
            cyc++;
            if (done === 1'b1) dc++;
            if (err === 1'b1) ec++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0; ext_in = '0;
        tick();
        n_checks++; if ({busy, done, err} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, err}); else n_pass++;
        n_checks++; if (result !== 16'h0) $display("FAIL reset_result got %h want 0000", result); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic load_add_prog();
        prog_tab[0] = enc(3'b101, 4'd0, 4'd0, 4'd0, 5'd0);
        prog_tab[1] = enc(3'b101, 4'd0, 4'd0, 4'd1, 5'd0);
        prog_tab[2] = enc(3'b000, 4'd0, 4'd1, 4'd2, 5'd0);
        prog_tab[3] = enc(3'b111, 4'd0, 4'd0, 4'd0, 5'd0);
        load_prog(4);
    endtask

    task automatic test_add();
        int bc, dc, ec;
        load_add_prog();
        clear_ext(); ext_tab[0] = 16'd5; ext_tab[1] = 16'd7;
        run_prog(60, -1, bc, dc, ec);
        n_checks++; if (result !== 16'd12) $display("FAIL add_result got %0d want 12", result); else n_pass++;
        n_checks++; if (bc !== 4) $display("FAIL add_busy_cycles got %0d want 4", bc); else n_pass++;
        n_checks++; if (dc !== 1) $display("FAIL add_done_pulse got %0d want 1", dc); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b0) $display("FAIL add_done_width got %b want 0", done); else n_pass++;
    endtask

    task automatic test_alu(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] exp, input string name);
        int bc, dc, ec;
        prog_tab[0] = enc(3'b101, 4'd0, 4'd0, 4'd4, 5'd0);
        prog_tab[1] = enc(3'b101, 4'd0, 4'd0, 4'd5, 5'd0);
        prog_tab[2] = enc(op,     4'd4, 4'd5, 4'd2, 5'd0);
        prog_tab[3] = enc(3'b111, 4'd0, 4'd0, 4'd0, 5'd0);
        load_prog(4);
        clear_ext(); ext_tab[0] = x; ext_tab[1] = y;
        run_prog(60, -1, bc, dc, ec);
        n_checks++; if (result !== exp) $display("FAIL %s got %h want %h", name, result, exp); else n_pass++;
        tick();
    endtask

    task automatic test_branch(input logic [1:0] cond, input logic [15:0] x, input logic [15:0] y,
                               input bit taken, input string name);
        int bc, dc, ec;
        prog_tab[0] = enc(3'b101, 4'd0, 4'd0, 4'd7, 5'd0);
        prog_tab[1] = enc(3'b101, 4'd0, 4'd0, 4'd8, 5'd0);
        prog_tab[2] = enc(3'b101, 4'd0, 4'd0, 4'd2, 5'd0);
        prog_tab[3] = enc(3'b110, 4'd7, 4'd8, {2'b11, cond}, 5'd5);
        prog_tab[4] = enc(3'b101, 4'd0, 4'd0, 4'd2, 5'd0);
        prog_tab[5] = enc(3'b111, 4'd0, 4'd0, 4'd0, 5'd0);
        load_prog(6);
        clear_ext(); ext_tab[0] = x; ext_tab[1] = y; ext_tab[2] = 16'h0011; ext_tab[4] = 16'h0022;
        run_prog(60, -1, bc, dc, ec);
        n_checks++;
        if (result !== (taken ? 16'h0011 : 16'h0022) || bc !== (taken ? 5 : 6))
            $display("FAIL %s got result=%h busy=%0d want result=%h busy=%0d",
                     name, result, bc, taken ? 16'h0011 : 16'h0022, taken ? 5 : 6);
        else n_pass++;
        tick();
    endtask

    task automatic load_loop_prog();
        prog_tab[0] = enc(3'b101, 4'd0, 4'd0, 4'd0, 5'd0);
        prog_tab[1] = enc(3'b101, 4'd0, 4'd0, 4'd1, 5'd0);
        prog_tab[2] = enc(3'b101, 4'd0, 4'd0, 4'd2, 5'd0);
        prog_tab[3] = enc(3'b101, 4'd0, 4'd0, 4'd3, 5'd0);
        prog_tab[4] = enc(3'b001, 4'd0, 4'd1, 4'd0, 5'd0);
        prog_tab[5] = enc(3'b000, 4'd2, 4'd1, 4'd2, 5'd0);
        prog_tab[6] = enc(3'b110, 4'd0, 4'd3, 4'd3, 5'd8);
        prog_tab[7] = enc(3'b110, 4'd0, 4'd0, 4'd0, 5'd4);
        prog_tab[8] = enc(3'b111, 4'd0, 4'd0, 4'd0, 5'd0);
        load_prog(9);
        clear_ext(); ext_tab[0] = 16'd10; ext_tab[1] = 16'd1;
    endtask

    task automatic test_loop();
        int bc, dc, ec;
        load_loop_prog();
        run_prog(60, -1, bc, dc, ec);
        n_checks++; if (result !== 16'd10) $display("FAIL loop_result got %0d want 10", result); else n_pass++;
        n_checks++; if (bc !== 44) $display("FAIL loop_busy_cycles got %0d want 44", bc); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int bc, dc, ec;
        load_add_prog();
        clear_ext(); ext_tab[0] = 16'd5; ext_tab[1] = 16'd7;
        run_prog(60, 1, bc, dc, ec);
        n_checks++; if (result !== 16'd12 || bc !== 4) $display("FAIL run_ignores_start_we got result=%0d busy=%0d want 12/4", result, bc); else n_pass++;
        n_checks++; if (done !== 1'b1) $display("FAIL done_before_restart got %b want 1", done); else n_pass++;
        // Restart issued in the done cycle; also proves the RUN-time write never landed.
        clear_ext(); ext_tab[0] = 16'd1; ext_tab[1] = 16'd2;
        run_prog(60, -1, bc, dc, ec);
        n_checks++; if (result !== 16'd3 || bc !== 4 || dc !== 1) $display("FAIL restart_in_done got result=%0d busy=%0d done=%0d want 3/4/1", result, bc, dc); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_run();
        int bc, dc, ec;
        load_loop_prog();
        start = 1'b1;
        tick();
        start = 1'b0;
        ext_in = ext_tab[0];
        tick();
        ext_in = ext_tab[1];
        tick();
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({busy, done} !== 2'b00) $display("FAIL midrun_reset_flags got %b want 00", {busy, done}); else n_pass++;
        n_checks++; if (result !== 16'h0) $display("FAIL midrun_reset_regs got %h want 0000", result); else n_pass++;
        #1 rst = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL post_reset_idle got %b want 0", busy); else n_pass++;
        run_prog(60, -1, bc, dc, ec);
        n_checks++; if (result !== 16'd10 || bc !== 44) $display("FAIL rerun_after_reset got result=%0d busy=%0d want 10/44", result, bc); else n_pass++;
        tick();
    endtask

    task automatic test_watchdog();
        int bc, dc, ec;
        prog_tab[0] = enc(3'b110, 4'd0, 4'd0, 4'd0, 5'd0);
        load_prog(1);
        clear_ext();
        run_prog(40, -1, bc, dc, ec);
`ifdef MICRO_DATAPATH_WDOG_EN
        n_checks++; if (bc !== 20 || ec !== 1) $display("FAIL wdog_abort got busy=%0d err=%0d want 20/1", bc, ec); else n_pass++;
        n_checks++; if (dc !== 0 || busy !== 1'b0) $display("FAIL wdog_no_done got done=%0d busy=%b want 0/0", dc, busy); else n_pass++;
`else
        n_checks++; if (bc !== 40 || busy !== 1'b1) $display("FAIL unbounded_run got busy_cycles=%0d busy=%b want 40/1", bc, busy); else n_pass++;
        n_checks++; if (dc !== 0 || ec !== 0) $display("FAIL unbounded_no_pulse got done=%0d err=%0d want 0/0", dc, ec); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu(3'b001, 16'd3,     16'd5,     16'hFFFE, "sub_wrap");
        test_alu(3'b100, 16'h8001,  16'h0000,  16'h4000, "shr_zero_fill");
        test_alu(3'b010, 16'h0F0F,  16'h00FF,  16'h000F, "and");
        test_alu(3'b011, 16'h0F0F,  16'h00FF,  16'h0FFF, "or");
        test_branch(2'b10, 16'd6, 16'd0, 1'b1, "br_even_taken");
        test_branch(2'b10, 16'd7, 16'd0, 1'b0, "br_odd_not_taken");
        test_branch(2'b01, 16'd9, 16'd3, 1'b1, "br_gt_taken");
        test_branch(2'b01, 16'd5, 16'd5, 1'b0, "br_gt_equal_not_taken");
        test_branch(2'b11, 16'd5, 16'd5, 1'b1, "br_eq_taken");
        test_branch(2'b11, 16'd5, 16'd4, 1'b0, "br_eq_not_taken");
        test_loop();
        test_back_to_back();
        test_reset_mid_run();
        test_watchdog();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
